// File: rtl/ledsd_pkg.sv
// Shared address map and CTRL bit positions for the direct-drive seven-segment
// control stage.
package ledsd_pkg;

  localparam logic [3:0] LEDSD_CTRL       = 4'd0;
  localparam logic [3:0] LEDSD_DIG_EN     = 4'd1;
  localparam logic [3:0] LEDSD_DP         = 4'd2;
  localparam logic [3:0] LEDSD_BLINK_MASK = 4'd3;
  localparam logic [3:0] LEDSD_BLINK_DIV  = 4'd4;
  localparam logic [3:0] LEDSD_DIGIT_BASE = 4'd8;

  localparam int CTRL_COMMIT   = 0;
  localparam int CTRL_AUTO     = 1;
  localparam int CTRL_BLINK_EN = 2;

endpackage

// File: rtl/ledsd_blink_timer.sv
// Blink prescaler: pre counts 0..div, then wraps and toggles phase.
// Disable or clear forces pre and phase back to 0.
module ledsd_blink_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             phase
);

  logic [DIV_W-1:0] pre_q, pre_d;
  logic             phase_q, phase_d;

  // >= rather than == so a stale pre above div can never run to 2^DIV_W
  always_comb begin
    pre_d   = pre_q;
    phase_d = phase_q;
    if (clr || !en) begin
      pre_d   = '0;
      phase_d = 1'b0;
    end else if (pre_q >= div) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end else begin
      pre_d   = pre_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/ledsd_direct_ctrl.sv
// Register file, double-buffered digit codes and blink masking for a
// directly-wired seven-segment bank.
module ledsd_direct_ctrl
  import ledsd_pkg::*;
#(
  parameter int NUM    = 2,
  parameter int E_CODE = 0,
  parameter int DIV_W  = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wen,
  input  logic                          ren,
  input  logic [3:0]                    addr,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata,
  output logic [NUM-1:0][E_CODE+3:0]    data_in,
  output logic [NUM-1:0]                dig,
  output logic [NUM-1:0]                dp
);

  localparam int         CW    = 4 + E_CODE;
  localparam logic [3:0] NUM_A = 4'(NUM);

  logic                     auto_q, blink_q;
  logic [NUM-1:0]           dig_en_q, dp_q, mask_q;
  logic [DIV_W-1:0]         div_q;
  logic [NUM-1:0][CW-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     phase;

  logic       dig_hit, wr_ctrl, commit, wr_div;
  logic [2:0] dig_idx;
  logic       unused_wdata;

  assign dig_idx = addr[2:0];
  assign dig_hit = addr[3] && ({1'b0, dig_idx} < NUM_A);
  assign wr_ctrl = wen && (addr == LEDSD_CTRL);
  assign commit  = wr_ctrl && wdata[CTRL_COMMIT];
  assign wr_div  = wen && (addr == LEDSD_BLINK_DIV);
  assign unused_wdata = ^wdata;

  // Commit samples the pre-edge shadow, so a same-cycle digit write lands only
  // in shadow and is picked up by the next commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    for (int i = 0; i < NUM; i++) begin
      if (wen && dig_hit && dig_idx == 3'(i)) begin
        shadow_d[i] = wdata[CW-1:0];
        if (auto_q) active_d[i] = wdata[CW-1:0];
      end
    end
    if (commit) active_d = shadow_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (ren) begin
      rdata_d = '0;
      case (addr)
        LEDSD_CTRL:       rdata_d[CTRL_BLINK_EN:CTRL_AUTO] = {blink_q, auto_q};
        LEDSD_DIG_EN:     rdata_d[NUM-1:0]   = dig_en_q;
        LEDSD_DP:         rdata_d[NUM-1:0]   = dp_q;
        LEDSD_BLINK_MASK: rdata_d[NUM-1:0]   = mask_q;
        LEDSD_BLINK_DIV:  rdata_d[DIV_W-1:0] = div_q;
        default: begin
          for (int i = 0; i < NUM; i++)
            if (dig_hit && dig_idx == 3'(i)) rdata_d[CW-1:0] = shadow_q[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q   <= 1'b0;
      blink_q  <= 1'b0;
      dig_en_q <= '0;
      dp_q     <= '0;
      mask_q   <= '0;
      div_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (wr_ctrl) begin
        auto_q  <= wdata[CTRL_AUTO];
        blink_q <= wdata[CTRL_BLINK_EN];
      end
      if (wen && addr == LEDSD_DIG_EN)     dig_en_q <= wdata[NUM-1:0];
      if (wen && addr == LEDSD_DP)         dp_q     <= wdata[NUM-1:0];
      if (wen && addr == LEDSD_BLINK_MASK) mask_q   <= wdata[NUM-1:0];
      if (wr_div)                          div_q    <= wdata[DIV_W-1:0];
      shadow_q <= shadow_d;
      active_q <= active_d;
      rdata_q  <= rdata_d;
    end
  end

  ledsd_blink_timer #(.DIV_W(DIV_W)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (blink_q),
    .div   (div_q),
    .clr   (wr_div),
    .phase (phase)
  );

  // Outputs depend on registers only; no bus-to-display combinational path.
  assign data_in = active_q;
  assign dig     = dig_en_q & ~({NUM{blink_q & phase}} & mask_q);
  assign dp      = dp_q & dig;
  assign rdata   = rdata_q;

endmodule
